// File: rtl/cdb_issue_scheduler.sv
// Issue scheduler for four functional units that share one common data bus (CDB).
// A reservation vector tracks future CDB write slots so no two results ever land together.
module cdb_issue_scheduler #(
  parameter int LAT_INT  = 0,
  parameter int LAT_MEM  = 0,
  parameter int LAT_MULT = 3,
  parameter int LAT_DIV  = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ready_int,
  input  logic       i_ready_div,
  input  logic       i_ready_mult,
  input  logic       i_ready_mem,
  input  logic       i_hold,
  output logic       o_issue_int,
  output logic       o_issue_div,
  output logic       o_issue_mult,
  output logic       o_issue_mem,
  output logic [3:0] o_cdb_sel,
  output logic       o_div_busy,
  output logic [6:0] o_rsv
);

  logic [6:0]          rsv_q, rsv_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          div_cnt_q, div_cnt_d;
  logic [LAT_MULT-1:0] mult_chain_q, mult_chain_d;
  logic [LAT_DIV-1:0]  div_chain_q, div_chain_d;

  logic [3:0] elig;
  logic [3:0] grant;
  logic [1:0] idx;
  logic [1:0] winner;
  logic       found;

  // One-hot mark for the slot claimed L cycles ahead; latency-0 units claim nothing.
  function automatic logic [6:0] slot_mask(input int lat);
    slot_mask = '0;
    if (lat >= 1) slot_mask = 7'(1) << (lat - 1);
  endfunction

  always_comb begin
    elig[0] = i_ready_int  & ~rsv_q[LAT_INT];
    elig[1] = i_ready_div  & ~rsv_q[LAT_DIV] & (div_cnt_q == 3'd0);
    elig[2] = i_ready_mult & ~rsv_q[LAT_MULT];
    elig[3] = i_ready_mem  & ~rsv_q[LAT_MEM];
    if (i_hold || i_rst) elig = '0;
  end

  // Round-robin: first eligible unit at or above rr_ptr, wrapping around.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = found ? winner + 2'd1 : rr_ptr_q;

    rsv_d = {1'b0, rsv_q[6:1]};
    if (grant[0]) rsv_d = rsv_d | slot_mask(LAT_INT);
    if (grant[1]) rsv_d = rsv_d | slot_mask(LAT_DIV);
    if (grant[2]) rsv_d = rsv_d | slot_mask(LAT_MULT);
    if (grant[3]) rsv_d = rsv_d | slot_mask(LAT_MEM);

    if (grant[1])               div_cnt_d = 3'(LAT_DIV - 1);
    else if (div_cnt_q != 3'd0) div_cnt_d = div_cnt_q - 3'd1;
    else                        div_cnt_d = div_cnt_q;

    mult_chain_d = LAT_MULT'({mult_chain_q, grant[2]});
    div_chain_d  = LAT_DIV'({div_chain_q, grant[1]});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsv_q        <= '0;
      rr_ptr_q     <= '0;
      div_cnt_q    <= '0;
      mult_chain_q <= '0;
      div_chain_q  <= '0;
    end else begin
      rsv_q        <= rsv_d;
      rr_ptr_q     <= rr_ptr_d;
      div_cnt_q    <= div_cnt_d;
      mult_chain_q <= mult_chain_d;
      div_chain_q  <= div_chain_d;
    end
  end

  assign o_issue_int  = grant[0];
  assign o_issue_div  = grant[1];
  assign o_issue_mult = grant[2];
  assign o_issue_mem  = grant[3];
  assign o_cdb_sel    = {grant[3], mult_chain_q[LAT_MULT-1], div_chain_q[LAT_DIV-1], grant[0]};
  assign o_div_busy   = (div_cnt_q != 3'd0);
  assign o_rsv        = rsv_q;

  // A multi-hot CDB select means the reservation bookkeeping is broken.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert ($onehot0(o_cdb_sel));
  end

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Directed bench for cdb_issue_scheduler: contention, slot collisions, divider occupancy, hold and reset.
// Vectors are {mem,mult,div,int}; outputs are sampled 1 time unit after the falling edge.
module tb_cdb_issue_scheduler;

  logic       clk;
  logic       rst;
  logic       hold;
  logic [3:0] ready;
  logic       issue_int, issue_div, issue_mult, issue_mem;
  logic [3:0] cdb_sel;
  logic       div_busy;
  logic [6:0] rsv;
  logic [3:0] issue_v;

  int tests_run    = 0;
  int tests_failed = 0;

  cdb_issue_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ready_int (ready[0]),
    .i_ready_div (ready[1]),
    .i_ready_mult(ready[2]),
    .i_ready_mem (ready[3]),
    .i_hold      (hold),
    .o_issue_int (issue_int),
    .o_issue_div (issue_div),
    .o_issue_mult(issue_mult),
    .o_issue_mem (issue_mem),
    .o_cdb_sel   (cdb_sel),
    .o_div_busy  (div_busy),
    .o_rsv       (rsv)
  );

  assign issue_v = {issue_mem, issue_mult, issue_div, issue_int};

  // Clock and initial input state
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs for one cycle and settle the combinational outputs
  task automatic drive(input logic [3:0] rdy, input logic h, input logic r);
    @(negedge clk);
    ready = rdy;
    hold  = h;
    rst   = r;
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 1'b0, 1'b1);
    drive(4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive(4'hF, 1'b0, 1'b1);
    tests_run++;
    if (issue_v !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_issue got %b want 0000", issue_v);
    end
    drive(4'h0, 1'b0, 1'b0);
    tests_run++;
    if (rsv !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset_rsv got %h want 00", rsv);
    end
    tests_run++;
    if (cdb_sel !== 4'b0000 || div_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cdb_busy got %b/%b want 0000/0", cdb_sel, div_busy);
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg [0:8];
    logic [3:0] ec [0:8];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
    ec = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(4'hF, 1'b0, 1'b0);
      tests_run++;
      if (issue_v !== eg[c]) begin
        tests_failed++;
        $display("FAIL contention_issue c%0d got %b want %b", c, issue_v, eg[c]);
      end
      tests_run++;
      if (cdb_sel !== ec[c]) begin
        tests_failed++;
        $display("FAIL contention_cdb c%0d got %b want %b", c, cdb_sel, ec[c]);
      end
      if (c == 2) begin
        tests_run++;
        if (div_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL contention_busy got %b want 1", div_busy);
        end
      end
    end
  endtask

  task automatic test_slot_collision();
    logic [3:0] rv [0:7];
    logic [3:0] eg [0:7];
    logic [3:0] ec [0:7];
    rv = '{4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    eg = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    ec = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(rv[c], 1'b0, 1'b0);
      tests_run++;
      if (issue_v !== eg[c]) begin
        tests_failed++;
        $display("FAIL collision_issue c%0d got %b want %b", c, issue_v, eg[c]);
      end
      tests_run++;
      if (cdb_sel !== ec[c]) begin
        tests_failed++;
        $display("FAIL collision_cdb c%0d got %b want %b", c, cdb_sel, ec[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (rsv !== 7'h08) begin
          tests_failed++;
          $display("FAIL collision_rsv got %h want 08", rsv);
        end
      end
    end
  endtask

  task automatic test_lat0_block();
    logic [3:0] rv [0:4];
    logic [3:0] eg [0:4];
    logic [3:0] ec [0:4];
    rv = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    eg = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    ec = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(rv[c], 1'b0, 1'b0);
      tests_run++;
      if (issue_v !== eg[c] || cdb_sel !== ec[c]) begin
        tests_failed++;
        $display("FAIL lat0_block c%0d got %b/%b want %b/%b", c, issue_v, cdb_sel, eg[c], ec[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (rsv !== 7'h01) begin
          tests_failed++;
          $display("FAIL lat0_rsv got %h want 01", rsv);
        end
      end
    end
  endtask

  task automatic test_div_occupancy();
    logic [3:0] eg;
    logic [3:0] ec;
    logic       eb;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(4'b0010, 1'b0, 1'b0);
      eg = (c % 6 == 0) ? 4'b0010 : 4'b0000;
      ec = (c == 6 || c == 12) ? 4'b0010 : 4'b0000;
      eb = (c % 6 != 0);
      tests_run++;
      if (issue_v !== eg || cdb_sel !== ec || div_busy !== eb) begin
        tests_failed++;
        $display("FAIL div_occupancy c%0d got %b/%b/%b want %b/%b/%b",
                 c, issue_v, cdb_sel, div_busy, eg, ec, eb);
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [3:0] ec;
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    tests_run++;
    if (issue_v !== 4'b0100) begin
      tests_failed++;
      $display("FAIL hold_mult_grant got %b want 0100", issue_v);
    end
    for (int c = 1; c < 5; c++) begin
      drive(4'hF, 1'b1, 1'b0);
      ec = (c == 3) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (issue_v !== 4'b0000 || cdb_sel !== ec) begin
        tests_failed++;
        $display("FAIL hold_c%0d got %b/%b want 0000/%b", c, issue_v, cdb_sel, ec);
      end
      if (c == 1) begin
        tests_run++;
        if (rsv !== 7'h04) begin
          tests_failed++;
          $display("FAIL hold_rsv got %h want 04", rsv);
        end
      end
    end
    // Pointer sits at mem after the mult grant, so div wins via wrap-around.
    drive(4'b0010, 1'b0, 1'b0);
    tests_run++;
    if (issue_v !== 4'b0010) begin
      tests_failed++;
      $display("FAIL hold_div_grant got %b want 0010", issue_v);
    end
    drive(4'hF, 1'b0, 1'b1);
    tests_run++;
    if (issue_v !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_issue got %b want 0000", issue_v);
    end
    for (int c = 7; c < 14; c++) begin
      drive(4'h0, 1'b0, 1'b0);
      tests_run++;
      if (cdb_sel !== 4'b0000 || rsv !== 7'h00 || div_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_c%0d got %b/%h/%b want 0000/00/0", c, cdb_sel, rsv, div_busy);
      end
    end
  endtask

  initial begin
    ready = 4'h0;
    hold  = 1'b0;
    rst   = 1'b1;
    test_reset();
    test_contention();
    test_slot_collision();
    test_lat0_block();
    test_div_occupancy();
    test_hold_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
